// File: rtl/model_loader.sv
// Parses framed UART packets (target, address, count, records, XOR checksum) and
// streams little-endian records as single-cycle writes to the four model memories.
module model_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic [3:0]  wr_en_out,
  output logic [12:0] wr_addr_out,
  output logic [95:0] wr_data_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_COUNT_LO,
    S_COUNT_HI,
    S_PAYLOAD,
    S_CHECK
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [1:0]  tsel;
  logic [15:0] addr;
  logic [15:0] count;
  logic [3:0]  byte_cnt;
  logic [95:0] rec, rec_full;
  logic [7:0]  chk;
  logic [31:0] timer;
  logic        tgt_ok, rec_last, done_fire, err_fire;
  logic [12:0] addr_trunc;

  // Record with the current byte merged in, so the write can issue on its final byte.
  always_comb begin
    rec_full = rec;
    rec_full[{byte_cnt, 3'b000} +: 8] = rx_data_in;
    rec_last = (tsel == 2'd0) ? (byte_cnt == 4'd4) : (byte_cnt == 4'd11);
    tgt_ok   = (rx_data_in >= 8'h01) && (rx_data_in <= 8'h04);
    case (tsel)
      2'd0:       addr_trunc = addr[12:0];
      2'd1, 2'd2: addr_trunc = {2'b00, addr[10:0]};
      default:    addr_trunc = {8'h00, addr[4:0]};
    endcase
  end

  always_comb begin
    state_next = state;
    done_fire  = 1'b0;
    err_fire   = 1'b0;
    if (state != S_IDLE && !rx_valid_in && timer == TIMER_LAST) begin
      err_fire   = 1'b1;
      state_next = S_IDLE;
    end else if (rx_valid_in) begin
      case (state)
        S_IDLE: begin
          if (tgt_ok) state_next = S_ADDR_LO;
          else        err_fire   = 1'b1;
        end
        S_ADDR_LO:  state_next = S_ADDR_HI;
        S_ADDR_HI:  state_next = S_COUNT_LO;
        S_COUNT_LO: state_next = S_COUNT_HI;
        S_COUNT_HI: state_next = ({rx_data_in, count[7:0]} == 16'd0) ? S_CHECK : S_PAYLOAD;
        S_PAYLOAD: begin
          if (rec_last && count == 16'd1) state_next = S_CHECK;
        end
        S_CHECK: begin
          state_next = S_IDLE;
          if (rx_data_in == chk) done_fire = 1'b1;
          else                   err_fire  = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= S_IDLE;
      tsel        <= '0;
      addr        <= '0;
      count       <= '0;
      byte_cnt    <= '0;
      rec         <= '0;
      chk         <= '0;
      timer       <= '0;
      wr_en_out   <= '0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
      done_out    <= 1'b0;
      error_out   <= 1'b0;
    end else begin
      state     <= state_next;
      done_out  <= done_fire;
      error_out <= err_fire;
      wr_en_out <= '0;
      if (rx_valid_in || state_next == S_IDLE) timer <= '0;
      else                                     timer <= timer + 32'd1;
      if (rx_valid_in) begin
        if (state != S_IDLE) chk <= chk ^ rx_data_in;
        case (state)
          S_IDLE: begin
            if (tgt_ok) begin
              tsel     <= rx_data_in[1:0] - 2'd1;
              chk      <= rx_data_in;
              byte_cnt <= '0;
            end
          end
          S_ADDR_LO:  addr[7:0]   <= rx_data_in;
          S_ADDR_HI:  addr[15:8]  <= rx_data_in;
          S_COUNT_LO: count[7:0]  <= rx_data_in;
          S_COUNT_HI: count[15:8] <= rx_data_in;
          S_PAYLOAD: begin
            rec <= rec_full;
            if (rec_last) begin
              byte_cnt    <= '0;
              addr        <= addr + 16'd1;
              count       <= count - 16'd1;
              wr_en_out   <= 4'b0001 << tsel;
              wr_addr_out <= addr_trunc;
              wr_data_out <= (tsel == 2'd0) ? {60'h0, rec_full[35:0]} : rec_full;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_out = (state != S_IDLE);

endmodule
